// File: rtl/mtl_pkg.sv
// rtl/mtl_pkg.sv - shared panel timing, pixel and state types for the MTL transmitter
package mtl_pkg;

    localparam int MTL_H_TOTAL     = 1056;
    localparam int MTL_V_TOTAL     = 525;
    localparam int MTL_H_SYNC_W    = 30;
    localparam int MTL_V_SYNC_W    = 13;
    localparam int MTL_H_ACT_START = 50;
    localparam int MTL_V_ACT_START = 23;
    localparam int MTL_H_ACT       = 800;
    localparam int MTL_V_ACT       = 480;
    localparam int MTL_FETCH_LAT   = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } lcd_state_t;

    typedef struct packed {
        logic hsd_n;
        logic vsd_n;
        logic act;
        logic fs;
    } sync_t;

    localparam sync_t SYNC_IDLE = sync_t'(4'b1100);

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mtl_timing_cnt.sv
// rtl/mtl_timing_cnt.sv - h/v scan counters with raw sync and active-window decode
module mtl_timing_cnt
    import mtl_pkg::*;
#(
    parameter int H_TOTAL     = MTL_H_TOTAL,
    parameter int V_TOTAL     = MTL_V_TOTAL,
    parameter int H_SYNC_W    = MTL_H_SYNC_W,
    parameter int V_SYNC_W    = MTL_V_SYNC_W,
    parameter int H_ACT_START = MTL_H_ACT_START,
    parameter int V_ACT_START = MTL_V_ACT_START,
    parameter int H_ACT       = MTL_H_ACT,
    parameter int V_ACT       = MTL_V_ACT,
    parameter int HW          = cnt_w(H_TOTAL),
    parameter int VW          = cnt_w(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_run,
    output logic [HW-1:0] o_h,
    output logic [VW-1:0] o_v,
    output logic          o_origin,
    output logic          o_frame_end,
    output logic          o_hsd_n,
    output logic          o_vsd_n,
    output logic          o_act
);

    // Compare one bit wider so an active window ending exactly at H_TOTAL still fits.
    localparam logic [HW:0] H_LAST = (HW+1)'(H_TOTAL - 1);
    localparam logic [HW:0] H_SYNC = (HW+1)'(H_SYNC_W);
    localparam logic [HW:0] H_A0   = (HW+1)'(H_ACT_START);
    localparam logic [HW:0] H_A1   = (HW+1)'(H_ACT_START + H_ACT);
    localparam logic [VW:0] V_LAST = (VW+1)'(V_TOTAL - 1);
    localparam logic [VW:0] V_SYNC = (VW+1)'(V_SYNC_W);
    localparam logic [VW:0] V_A0   = (VW+1)'(V_ACT_START);
    localparam logic [VW:0] V_A1   = (VW+1)'(V_ACT_START + V_ACT);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [HW:0]   h_x;
    logic [VW:0]   v_x;
    logic          line_end;
    logic          frame_last_line;

    assign h_x             = {1'b0, h_q};
    assign v_x             = {1'b0, v_q};
    assign line_end        = (h_x == H_LAST);
    assign frame_last_line = (v_x == V_LAST);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (i_run) begin
            if (line_end) begin
                h_d = '0;
                v_d = frame_last_line ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign o_h         = h_q;
    assign o_v         = v_q;
    assign o_origin    = (h_q == '0) && (v_q == '0);
    assign o_frame_end = line_end && frame_last_line;
    assign o_hsd_n     = (h_x >= H_SYNC);
    assign o_vsd_n     = (v_x >= V_SYNC);
    assign o_act       = (h_x >= H_A0) && (h_x < H_A1) && (v_x >= V_A0) && (v_x < V_A1);

endmodule

// File: rtl/mtl_lcd_tx.sv
// rtl/mtl_lcd_tx.sv - MTL panel transmitter: scan FSM, pixel fetch and sync/RGB alignment
module mtl_lcd_tx
    import mtl_pkg::*;
#(
    parameter int H_TOTAL     = MTL_H_TOTAL,
    parameter int V_TOTAL     = MTL_V_TOTAL,
    parameter int H_SYNC_W    = MTL_H_SYNC_W,
    parameter int V_SYNC_W    = MTL_V_SYNC_W,
    parameter int H_ACT_START = MTL_H_ACT_START,
    parameter int V_ACT_START = MTL_V_ACT_START,
    parameter int H_ACT       = MTL_H_ACT,
    parameter int V_ACT       = MTL_V_ACT,
    parameter int FETCH_LAT   = MTL_FETCH_LAT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic        o_pix_req,
    output logic [9:0]  o_pix_x,
    output logic [8:0]  o_pix_y,
    input  logic [23:0] i_pix_rgb,
    output logic        o_hsd,
    output logic        o_vsd,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_frame_start,
    output logic        o_busy
);

    localparam int HW = cnt_w(H_TOTAL);
    localparam int VW = cnt_w(V_TOTAL);

    if (H_SYNC_W >= H_ACT_START || H_ACT_START + H_ACT > H_TOTAL ||
        V_SYNC_W >= V_ACT_START || V_ACT_START + V_ACT > V_TOTAL) begin : g_bad_timing
        $fatal(1, "mtl_lcd_tx: inconsistent panel timing parameters");
    end
    if (FETCH_LAT < 1 || FETCH_LAT > 4) begin : g_bad_lat
        $fatal(1, "mtl_lcd_tx: FETCH_LAT must be 1..4");
    end

    lcd_state_t    state_q, state_d;
    logic          running;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          origin, frame_end, hsd_n, vsd_n, act;
    sync_t         raw;
    sync_t         pipe_q [FETCH_LAT];
    sync_t         pipe_d [FETCH_LAT];
    sync_t         out_q, out_d;
    rgb_t          rgb_q, rgb_d;

    assign running = (state_q != IDLE);

    mtl_timing_cnt #(
        .H_TOTAL     (H_TOTAL),
        .V_TOTAL     (V_TOTAL),
        .H_SYNC_W    (H_SYNC_W),
        .V_SYNC_W    (V_SYNC_W),
        .H_ACT_START (H_ACT_START),
        .V_ACT_START (V_ACT_START),
        .H_ACT       (H_ACT),
        .V_ACT       (V_ACT),
        .HW          (HW),
        .VW          (VW)
    ) u_cnt (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_run       (running),
        .o_h         (h),
        .o_v         (v),
        .o_origin    (origin),
        .o_frame_end (frame_end),
        .o_hsd_n     (hsd_n),
        .o_vsd_n     (vsd_n),
        .o_act       (act)
    );

    // i_en is only honoured at the frame boundary; mid-frame drops just arm STOP_PEND.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (i_en) state_d = RUN;
            RUN:       if (!i_en) state_d = frame_end ? IDLE : STOP_PEND;
            STOP_PEND: begin
                if (frame_end)  state_d = i_en ? RUN : IDLE;
                else if (i_en)  state_d = RUN;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        raw = SYNC_IDLE;
        if (running) begin
            raw.hsd_n = hsd_n;
            raw.vsd_n = vsd_n;
            raw.act   = act;
            raw.fs    = origin && (state_q == RUN);
        end
    end

    assign o_pix_req = raw.act;
    assign o_pix_x   = raw.act ? 10'(h - HW'(H_ACT_START)) : 10'd0;
    assign o_pix_y   = raw.act ? 9'(v - VW'(V_ACT_START)) : 9'd0;

    // Timing travels FETCH_LAT stages so the last stage lines up with the returned pixel.
    always_comb begin
        pipe_d[0] = raw;
        for (int i = 1; i < FETCH_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        out_d = pipe_q[FETCH_LAT-1];
        rgb_d = pipe_q[FETCH_LAT-1].act ? rgb_t'(i_pix_rgb) : rgb_t'(24'd0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < FETCH_LAT; i++) begin
                pipe_q[i] <= SYNC_IDLE;
            end
            out_q <= SYNC_IDLE;
            rgb_q <= '0;
        end else begin
            for (int i = 0; i < FETCH_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            out_q <= out_d;
            rgb_q <= rgb_d;
        end
    end

    assign o_hsd         = out_q.hsd_n;
    assign o_vsd         = out_q.vsd_n;
    assign o_frame_start = out_q.fs;
    assign o_r           = rgb_q.r;
    assign o_g           = rgb_q.g;
    assign o_b           = rgb_q.b;
    assign o_busy        = running;

endmodule

// File: tb/tb_mtl_lcd_tx.sv
// tb/tb_mtl_lcd_tx.sv - scoreboard bench for mtl_lcd_tx on a scaled-down panel timing
module tb_mtl_lcd_tx;

    localparam int HT  = 20;
    localparam int VT  = 8;
    localparam int HS  = 3;
    localparam int VS  = 2;
    localparam int HA0 = 5;
    localparam int VA0 = 3;
    localparam int HA  = 10;
    localparam int VA  = 4;
    localparam int L   = 2;
    localparam int F   = HT * VT;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
    } xy_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] pix_rgb;
    logic        o_pix_req, o_hsd, o_vsd, o_frame_start, o_busy;
    logic [9:0]  o_pix_x;
    logic [8:0]  o_pix_y;
    logic [7:0]  o_r, o_g, o_b;

    xy_t req_q [$];
    xy_t pix_q [$];
    int  fs_q  [$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    mtl_lcd_tx #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_W(HS), .V_SYNC_W(VS),
        .H_ACT_START(HA0), .V_ACT_START(VA0), .H_ACT(HA), .V_ACT(VA), .FETCH_LAT(L)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .o_pix_req(o_pix_req), .o_pix_x(o_pix_x), .o_pix_y(o_pix_y), .i_pix_rgb(pix_rgb),
        .o_hsd(o_hsd), .o_vsd(o_vsd), .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_frame_start(o_frame_start), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_hsd"}, int'(o_hsd), 1);
        check({tag, "_vsd"}, int'(o_vsd), 1);
        check({tag, "_rgb"}, int'({o_r, o_g, o_b}), 0);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_fs"}, int'(o_frame_start), 0);
        check({tag, "_req"}, int'(o_pix_req), 0);
    endtask

    task automatic push_frame(input int nreq, input int npix);
        xy_t e;
        for (int i = 0; i < HA * VA; i++) begin
            e.x = 10'(i % HA);
            e.y = 9'(i / HA);
            if (i < nreq) req_q.push_back(e);
            if (i < npix) pix_q.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    // Pixel port model: returns {x, y, A5} exactly L clocks after each request, junk otherwise.
    initial begin
        xy_t  dl_xy  [L+1];
        logic dl_req [L+1];
        pix_rgb = 24'd0;
        for (int i = 0; i <= L; i++) begin
            dl_req[i] = 1'b0;
            dl_xy[i]  = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = L; i > 0; i--) begin
                dl_req[i] = dl_req[i-1];
                dl_xy[i]  = dl_xy[i-1];
            end
            dl_req[0]  = o_pix_req;
            dl_xy[0].x = o_pix_x;
            dl_xy[0].y = o_pix_y;
            pix_rgb = dl_req[L] ? {dl_xy[L].x[7:0], dl_xy[L].y[7:0], 8'hA5} : 24'hFFFFFF;
        end
    end

    // Monitor: a panel-side sampler counting columns/lines from the sync falling edges.
    initial begin
        logic        hp, vp, hfall, vfall;
        int          hlow, vlow, col, line, efc;
        xy_t         e;
        logic [23:0] er;
        hp = 1'b1; vp = 1'b1; hlow = 0; vlow = 0; col = 0; line = 0;
        forever begin
            @(negedge clk);
            hfall = hp & ~o_hsd;
            vfall = vp & ~o_vsd;
            if (!o_hsd)   hlow = hfall ? 1 : hlow + 1;
            else if (!hp) check("hsd_low_width", hlow, HS);
            if (!o_vsd)   vlow = vfall ? 1 : vlow + 1;
            else if (!vp) check("vsd_low_width", vlow, VS * HT);
            if (vfall) check("sync_edge_align", int'(hfall), 1);
            if (hfall) begin
                col  = 0;
                line = vfall ? 0 : line + 1;
            end else begin
                col++;
            end
            if ({o_r, o_g, o_b} != 24'd0) begin
                if (pix_q.size() == 0) begin
                    check("unexpected_rgb", int'({o_r, o_g, o_b}), 0);
                end else begin
                    e  = pix_q.pop_front();
                    er = {e.x[7:0], e.y[7:0], 8'hA5};
                    check("rgb_value", int'({o_r, o_g, o_b}), int'(er));
                    check("rgb_column", col, HA0 + int'(e.x));
                    check("rgb_line", line, VA0 + int'(e.y));
                end
            end
            if (o_pix_req) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", int'(o_pix_req), 0);
                end else begin
                    e = req_q.pop_front();
                    check("req_xy", int'({o_pix_x, o_pix_y}), int'(e));
                end
            end
            if (o_frame_start) begin
                if (fs_q.size() == 0) begin
                    check("unexpected_frame_start", int'(o_frame_start), 0);
                end else begin
                    efc = fs_q.pop_front();
                    check("frame_start_cycle", cyc, efc);
                    check("frame_start_syncs", int'({o_hsd, o_vsd}), 0);
                end
            end
            hp = o_hsd;
            vp = o_vsd;
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("in_reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_idle("post_reset");

        // Three frames; i_en blips in frame 2, drops for good at line 5 of frame 3.
        k  = cyc;
        en = 1'b1;
        for (int f = 0; f < 3; f++) fs_q.push_back(k + L + 2 + f * F);
        repeat (3) push_frame(HA * VA, HA * VA);
        wait_cyc(k + 1 + F + 50);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        wait_cyc(k + 1 + 2 * F + 5 * HT + 7);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_stop_pend", int'(o_busy), 1);
        wait_cyc(k + 1 + 3 * F + L + 1);
        check_idle("after_stop");
        repeat (10) @(negedge clk);
        check_idle("idle_hold");

        // Restart, then reset at raw h=10 line 5 (y=2): x 0..5 requested, x 0..2 shown.
        k  = cyc;
        en = 1'b1;
        fs_q.push_back(k + L + 2);
        push_frame(2 * HA + 6, 2 * HA + 3);
        wait_cyc(k + 1 + 5 * HT + 10);
        #1;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        check_idle("async_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_idle("after_reset_release");

        k  = cyc;
        en = 1'b1;
        fs_q.push_back(k + L + 2);
        push_frame(HA * VA, HA * VA);
        wait_cyc(k + 1 + 30);
        en = 1'b0;
        wait_cyc(k + 1 + F + L + 1);
        check_idle("final_idle");
        repeat (10) @(negedge clk);

        check("pending_frame_starts", fs_q.size(), 0);
        check("pending_pixels", pix_q.size(), 0);
        check("pending_requests", req_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
